// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deserialiser.
package uart_rx_pkg;

    localparam int OVS           = 16;
    localparam int S0            = 7;
    localparam int S1            = 8;
    localparam int S2            = 9;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sync_vote.sv
// RxD synchroniser plus a 3-sample majority voter clocked by the 16x baud tick.
module rx_sync_vote
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic rxd,
    output logic rxd_s,
    output logic vote
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [1:0] samp_q, samp_d;

    always_comb begin
        sync1_d = rxd;
        sync2_d = sync1_q;
        samp_d  = tick_en ? {samp_q[0], sync2_q} : samp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            samp_q  <= 2'b11;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            samp_q  <= samp_d;
        end
    end

    // The third sample is the live one, so a decision on a tick includes that tick's sample.
    assign rxd_s = sync2_q;
    assign vote  = maj3(samp_q[1], samp_q[0], sync2_q);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive front-end: start validation, deserialisation, parity/stop checks
// and a one-entry holding register on a valid/ready handshake.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = uart_rx_pkg::OVS
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Baud_16x_en,
    input  logic                 Cfg_par_en,
    input  logic                 Cfg_par_odd,
    input  logic                 Cfg_stop2,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 Rx_vld,
    input  logic                 Rx_rdy,
    output logic                 Rx_frm_err,
    output logic                 Rx_par_err,
    output logic                 Rx_brk,
    output logic                 Rx_ovr_err,
    input  logic                 Err_clr,
    output logic                 Busy
);

    localparam int CW  = $clog2(OVS);
    localparam int BCW = $clog2(DATA_BITS_MAX);

    logic rxd_s, vote;

    rx_sync_vote u_sync_vote (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .tick_en (Baud_16x_en),
        .rxd     (RxD),
        .rxd_s   (rxd_s),
        .vote    (vote)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_nx;
    logic [BCW-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0] shr_q, shr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
    logic zero_q, zero_d, frm_q, frm_d, par_q, par_d, brk_q, brk_d;
    logic wait_q, wait_d, busy_q, busy_d, vld_q, vld_d;
    logic frm_o_q, frm_o_d, par_o_q, par_o_d, brk_o_q, brk_o_d, ovr_q, ovr_d;
    logic dec, complete, accept, load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shr_d     = shr_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        zero_d    = zero_q;
        frm_d     = frm_q;
        par_d     = par_q;
        brk_d     = brk_q;
        wait_d    = wait_q;
        complete  = 1'b0;
        cnt_nx    = cnt_q + 1'b1;
        dec       = Baud_16x_en && (cnt_nx == CW'(S2));

        if (Baud_16x_en && (state_q != IDLE)) cnt_d = cnt_nx;

        unique case (state_q)
            IDLE: begin
                if (Baud_16x_en) begin
                    // After a break, wait for the line to return high before re-arming.
                    if (wait_q) begin
                        if (rxd_s) wait_d = 1'b0;
                    end else if (!rxd_s) begin
                        state_d   = START;
                        cnt_d     = '0;
                        bit_d     = '0;
                        shr_d     = '0;
                        zero_d    = 1'b1;
                        frm_d     = 1'b0;
                        par_d     = 1'b0;
                        brk_d     = 1'b0;
                        par_en_d  = Cfg_par_en;
                        par_odd_d = Cfg_par_odd;
                        stop2_d   = Cfg_stop2;
                    end
                end
            end
            START: begin
                if (dec) state_d = vote ? IDLE : DATA;
            end
            DATA: begin
                if (dec) begin
                    shr_d = {vote, shr_q[DATA_BITS-1:1]};
                    if (vote) zero_d = 1'b0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BCW'(DATA_BITS - 1)) state_d = par_en_q ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (dec) begin
                    par_d = (^shr_q) ^ vote ^ par_odd_q;
                    if (vote) zero_d = 1'b0;
                    state_d = STOP1;
                end
            end
            STOP1: begin
                if (dec) begin
                    frm_d = !vote;
                    brk_d = !vote && zero_q;
                    if (stop2_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d  = IDLE;
                        complete = 1'b1;
                        wait_d   = !vote && zero_q;
                    end
                end
            end
            STOP2: begin
                if (dec) begin
                    if (!vote) frm_d = 1'b1;
                    state_d  = IDLE;
                    complete = 1'b1;
                    wait_d   = brk_q;
                end
            end
            default: state_d = IDLE;
        endcase

        accept  = vld_q && Rx_rdy;
        load    = complete && (!vld_q || accept);
        data_d  = data_q;
        frm_o_d = frm_o_q;
        par_o_d = par_o_q;
        brk_o_d = brk_o_q;
        vld_d   = vld_q;
        if (load) begin
            data_d  = shr_d;
            frm_o_d = frm_d;
            par_o_d = par_d;
            brk_o_d = brk_d;
            vld_d   = 1'b1;
        end else if (accept) begin
            vld_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (complete && !load) ovr_d = 1'b1;
        else if (Err_clr)      ovr_d = 1'b0;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shr_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            zero_q    <= 1'b0;
            frm_q     <= 1'b0;
            par_q     <= 1'b0;
            brk_q     <= 1'b0;
            wait_q    <= 1'b0;
            busy_q    <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            frm_o_q   <= 1'b0;
            par_o_q   <= 1'b0;
            brk_o_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shr_q     <= shr_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            zero_q    <= zero_d;
            frm_q     <= frm_d;
            par_q     <= par_d;
            brk_q     <= brk_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            frm_o_q   <= frm_o_d;
            par_o_q   <= par_o_d;
            brk_o_q   <= brk_o_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Rx_data    = data_q;
    assign Rx_vld     = vld_q;
    assign Rx_frm_err = frm_o_q;
    assign Rx_par_err = par_o_q;
    assign Rx_brk     = brk_o_q;
    assign Rx_ovr_err = ovr_q;
    assign Busy       = busy_q;

endmodule
